trigger_delay_loader: RTL and testbench

TRIGGER_DELAY_LOADER -- requirements
Module: trigger_delay_loader

---
 rtl/trigger_delay_loader.sv | 158 +++++++++++++++
 tb/tb_trigger_delay_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_delay_loader.sv
// Loads L1 trigger delay values into the delay table (single write, single
// read, fill-all) and verifies every write by reading the entry back.
module trigger_delay_loader #(
    parameter int unsigned NUM_L1      = 20,
    parameter int unsigned NUM_L1_BITS = 5,
    parameter int unsigned DELAY_BITS  = 4
) (
    input  logic                   sclk_i,
    input  logic                   rst_n_i,
    input  logic [1:0]             cmd_i,
    input  logic                   cmd_stb_i,
    input  logic [NUM_L1_BITS-1:0] cmd_addr_i,
    input  logic [DELAY_BITS-1:0]  cmd_data_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [NUM_L1_BITS-1:0] err_addr_o,
    output logic [DELAY_BITS-1:0]  rd_data_o,
    output logic [DELAY_BITS-1:0]  l1_delay_o,
    output logic [NUM_L1_BITS-1:0] l1_delay_addr_o,
    output logic                   l1_delay_stb_o,
    input  logic [DELAY_BITS-1:0]  l1_delay_rb_i
);

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_FILL  = 2'b11;

    localparam logic [NUM_L1_BITS-1:0] LAST_ADDR = NUM_L1_BITS'(NUM_L1 - 1);
    localparam logic [NUM_L1_BITS-1:0] ADDR_ONE  = NUM_L1_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WSTB,
        S_SETTLE,
        S_CAPTURE,
        S_RADDR,
        S_DONE
    } state_e;

    // M_BAD marks an out-of-range single access that only walks to DONE.
    typedef enum logic [1:0] {
        M_WRITE,
        M_READ,
        M_FILL,
        M_BAD
    } mode_e;

    state_e                  state_q, state_d;
    mode_e                   mode_q, mode_d;
    logic [NUM_L1_BITS-1:0]  addr_q, addr_d;
    logic [DELAY_BITS-1:0]   data_q, data_d;
    logic [NUM_L1_BITS-1:0]  err_addr_q, err_addr_d;
    logic [DELAY_BITS-1:0]   rd_data_q, rd_data_d;
    logic                    err_q, err_d;
    logic                    stb_q, stb_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // Next-state decode; outputs are derived from the next state so they are registered.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        addr_d     = addr_q;
        data_d     = data_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        rd_data_d  = rd_data_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_stb_i && (cmd_i != CMD_NOP)) begin
                    err_d      = 1'b0;
                    err_addr_d = '0;
                    if (cmd_i == CMD_FILL) begin
                        mode_d  = M_FILL;
                        addr_d  = '0;
                        data_d  = cmd_data_i;
                        state_d = S_WSTB;
                    end else if (cmd_addr_i > LAST_ADDR) begin
                        mode_d     = M_BAD;
                        err_d      = 1'b1;
                        err_addr_d = cmd_addr_i;
                        state_d    = S_RADDR;
                    end else if (cmd_i == CMD_WRITE) begin
                        mode_d  = M_WRITE;
                        addr_d  = cmd_addr_i;
                        data_d  = cmd_data_i;
                        state_d = S_WSTB;
                    end else begin
                        mode_d  = M_READ;
                        addr_d  = cmd_addr_i;
                        state_d = S_RADDR;
                    end
                end
            end
            S_WSTB:   state_d = S_SETTLE;
            S_SETTLE: state_d = S_CAPTURE;
            S_RADDR:  state_d = (mode_q == M_BAD) ? S_DONE : S_CAPTURE;
            S_CAPTURE: begin
                rd_data_d = l1_delay_rb_i;
                if ((mode_q != M_READ) && (l1_delay_rb_i != data_q)) begin
                    err_d      = 1'b1;
                    err_addr_d = addr_q;
                    state_d    = S_DONE;
                end else if ((mode_q == M_FILL) && (addr_q != LAST_ADDR)) begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = S_WSTB;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        stb_d  = (state_d == S_WSTB);
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // State and output registers; reset clears the strobe asynchronously.
    always_ff @(posedge sclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            mode_q     <= M_WRITE;
            addr_q     <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            rd_data_q  <= '0;
            stb_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            rd_data_q  <= rd_data_d;
            stb_q      <= stb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign err_addr_o      = err_addr_q;
    assign rd_data_o       = rd_data_q;
    assign l1_delay_o      = data_q;
    assign l1_delay_addr_o = addr_q;
    assign l1_delay_stb_o  = stb_q;

endmodule

// File: tb/tb_trigger_delay_loader.sv
// Directed bench for trigger_delay_loader with a behavioural delay-table model.
module tb_trigger_delay_loader;

    logic       sclk = 1'b0;
    logic       rst_n;
    logic [1:0] cmd;
    logic       cmd_stb;
    logic [4:0] cmd_addr;
    logic [3:0] cmd_data;
    logic       busy, done, err, stb;
    logic [4:0] err_addr, dly_addr;
    logic [3:0] rd_data, dly, rb;

    // Delay-table model: registered readback, optional forced-bad entry.
    logic [3:0] mem [32] = '{default: 4'h0};
    logic       force_en;
    logic [4:0] force_addr;

    int n_checks = 0;
    int n_errors = 0;

    int stb_addrs[$];
    int stb_cycs[$];
    int stb_bad_data;
    int consec;
    int done_cyc;
    logic busy_c1, busy_at_done, busy_after, done_after;

    always #5 sclk = ~sclk;

    trigger_delay_loader dut (
        .sclk_i          (sclk),
        .rst_n_i         (rst_n),
        .cmd_i           (cmd),
        .cmd_stb_i       (cmd_stb),
        .cmd_addr_i      (cmd_addr),
        .cmd_data_i      (cmd_data),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err),
        .err_addr_o      (err_addr),
        .rd_data_o       (rd_data),
        .l1_delay_o      (dly),
        .l1_delay_addr_o (dly_addr),
        .l1_delay_stb_o  (stb),
        .l1_delay_rb_i   (rb)
    );

    always @(posedge sclk) begin
        if (stb) mem[dly_addr] <= dly;
        rb <= (force_en && dly_addr == force_addr) ? 4'h0 : mem[dly_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
        check_eq({tag, "_err"}, 32'(err), 0);
        check_eq({tag, "_err_addr"}, 32'(err_addr), 0);
        check_eq({tag, "_rd_data"}, 32'(rd_data), 0);
        check_eq({tag, "_dly"}, 32'(dly), 0);
        check_eq({tag, "_dly_addr"}, 32'(dly_addr), 0);
        check_eq({tag, "_stb"}, 32'(stb), 0);
    endtask

    // Issue one command (caller sits just after a negedge) and trace it cycle by cycle.
    task automatic run_cmd(input logic [1:0] c, input logic [4:0] a, input logic [3:0] d,
                           input int budget, input int inject_cyc, input int abort_cyc);
        logic prev;
        stb_addrs.delete();
        stb_cycs.delete();
        stb_bad_data = 0;
        consec       = 0;
        done_cyc     = -1;
        busy_c1      = 1'b0;
        busy_at_done = 1'b1;
        busy_after   = 1'b1;
        done_after   = 1'b1;
        prev         = 1'b0;
        cmd = c; cmd_addr = a; cmd_data = d; cmd_stb = 1'b1;
        @(posedge sclk);
        #1 cmd_stb = 1'b0; cmd = 2'b00;
        for (int cy = 1; cy <= budget; cy++) begin
            @(negedge sclk);
            if (stb) begin
                stb_addrs.push_back(int'(dly_addr));
                stb_cycs.push_back(cy);
                if (dly != d) stb_bad_data++;
                if (prev) consec++;
            end
            prev = stb;
            if (cy == 1) busy_c1 = busy;
            if (done) begin
                done_cyc     = cy;
                busy_at_done = busy;
                break;
            end
            if (cy == abort_cyc) break;
            if (cy == inject_cyc) begin
                cmd = 2'b01; cmd_addr = 5'd3; cmd_data = 4'hF; cmd_stb = 1'b1;
                @(posedge sclk);
                #1 cmd_stb = 1'b0; cmd = 2'b00;
            end
        end
        if (done_cyc > 0) begin
            @(negedge sclk);
            busy_after = busy;
            done_after = done;
        end
    endtask

    task automatic check_fill_order(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < stb_addrs.size(); i++) begin
            if (stb_addrs[i] != i || stb_cycs[i] != 3 * i + 1) bad++;
        end
        check_eq({tag, "_stb_count"}, 32'(stb_addrs.size()), 32'(n));
        check_eq({tag, "_stb_order"}, 32'(bad), 0);
        check_eq({tag, "_stb_data"}, 32'(stb_bad_data), 0);
        check_eq({tag, "_stb_consec"}, 32'(consec), 0);
    endtask

    initial begin
        force_en = 1'b0; force_addr = 5'd5;
        cmd = 2'b00; cmd_stb = 1'b0; cmd_addr = '0; cmd_data = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge sclk);
        check_outputs_zero("reset");

        // Release and present the first command at the same time.
        rst_n = 1'b1;
        run_cmd(2'b01, 5'd7, 4'hA, 20, 0, 0);
        check_eq("wr7_busy_c1", 32'(busy_c1), 1);
        check_eq("wr7_stb_count", 32'(stb_addrs.size()), 1);
        if (stb_addrs.size() == 1) begin
            check_eq("wr7_stb_addr", 32'(stb_addrs[0]), 7);
            check_eq("wr7_stb_cyc", 32'(stb_cycs[0]), 1);
        end
        check_eq("wr7_stb_data", 32'(stb_bad_data), 0);
        check_eq("wr7_done_cyc", 32'(done_cyc), 4);
        check_eq("wr7_busy_at_done", 32'(busy_at_done), 0);
        check_eq("wr7_done_one_cycle", 32'(done_after), 0);
        check_eq("wr7_err", 32'(err), 0);
        check_eq("wr7_rd_data", 32'(rd_data), 32'hA);

        run_cmd(2'b11, 5'd0, 4'h3, 100, 0, 0);
        check_fill_order("fill3", 20);
        check_eq("fill3_done_cyc", 32'(done_cyc), 61);
        check_eq("fill3_err", 32'(err), 0);

        run_cmd(2'b10, 5'd7, 4'h0, 20, 0, 0);
        check_eq("rd7_stb_count", 32'(stb_addrs.size()), 0);
        check_eq("rd7_done_cyc", 32'(done_cyc), 3);
        check_eq("rd7_rd_data", 32'(rd_data), 32'h3);

        force_en = 1'b1;
        run_cmd(2'b11, 5'd0, 4'h3, 100, 0, 0);
        force_en = 1'b0;
        check_fill_order("fillerr", 6);
        check_eq("fillerr_done_cyc", 32'(done_cyc), 19);
        check_eq("fillerr_err", 32'(err), 1);
        check_eq("fillerr_err_addr", 32'(err_addr), 5);
        repeat (3) @(negedge sclk);
        check_eq("fillerr_err_sticky", 32'(err), 1);

        run_cmd(2'b10, 5'd4, 4'h0, 20, 0, 0);
        check_eq("rd4_err_cleared", 32'(err), 0);
        check_eq("rd4_err_addr_cleared", 32'(err_addr), 0);
        check_eq("rd4_rd_data", 32'(rd_data), 32'h3);

        run_cmd(2'b10, 5'd25, 4'h0, 20, 0, 0);
        check_eq("rd25_stb_count", 32'(stb_addrs.size()), 0);
        check_eq("rd25_done_cyc", 32'(done_cyc), 2);
        check_eq("rd25_err", 32'(err), 1);
        check_eq("rd25_err_addr", 32'(err_addr), 25);
        check_eq("rd25_rd_data_held", 32'(rd_data), 32'h3);

        run_cmd(2'b01, 5'd20, 4'h7, 20, 0, 0);
        check_eq("wr20_stb_count", 32'(stb_addrs.size()), 0);
        check_eq("wr20_done_cyc", 32'(done_cyc), 2);
        check_eq("wr20_err_addr", 32'(err_addr), 20);

        run_cmd(2'b01, 5'd19, 4'h5, 20, 0, 0);
        check_eq("wr19_stb_count", 32'(stb_addrs.size()), 1);
        if (stb_addrs.size() == 1) check_eq("wr19_stb_addr", 32'(stb_addrs[0]), 19);
        check_eq("wr19_done_cyc", 32'(done_cyc), 4);
        check_eq("wr19_err", 32'(err), 0);
        check_eq("wr19_rd_data", 32'(rd_data), 32'h5);

        // A strobe mid-fill must not disturb the sequence.
        run_cmd(2'b11, 5'd0, 4'h9, 100, 10, 0);
        check_fill_order("fillinj", 20);
        check_eq("fillinj_done_cyc", 32'(done_cyc), 61);
        check_eq("fillinj_err", 32'(err), 0);
        check_eq("fillinj_mem3", 32'(mem[3]), 32'h9);

        // Reset during SETTLE of address 10.
        run_cmd(2'b11, 5'd0, 4'h6, 100, 0, 32);
        check_eq("rstfill_stb_count", 32'(stb_addrs.size()), 11);
        check_eq("rstfill_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1 check_outputs_zero("rstfill");
        repeat (2) @(negedge sclk);
        rst_n = 1'b1;
        run_cmd(2'b10, 5'd10, 4'h0, 20, 0, 0);
        check_eq("rd10_done_cyc", 32'(done_cyc), 3);
        check_eq("rd10_rd_data", 32'(rd_data), 32'h6);
        check_eq("rd10_err", 32'(err), 0);

        // Reset while the strobe is high drops it without a clock edge.
        run_cmd(2'b11, 5'd0, 4'h2, 100, 0, 4);
        check_eq("rstwstb_stb_before", 32'(stb), 1);
        rst_n = 1'b0;
        #1 check_eq("rstwstb_stb_after", 32'(stb), 0);
        check_eq("rstwstb_addr_after", 32'(dly_addr), 0);
        repeat (2) @(negedge sclk);
        rst_n = 1'b1;
        run_cmd(2'b01, 5'd1, 4'hC, 20, 0, 0);
        check_eq("wr1_done_cyc", 32'(done_cyc), 4);
        check_eq("wr1_rd_data", 32'(rd_data), 32'hC);
        check_eq("wr1_err", 32'(err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
